serial_subtractor: RTL

Multi-cycle, parametrised N-bit subtractor computing a − b − bin, LSB-first, DIGIT bits per clock, using a chain of DIGIT full-subtractor cells plus one registered borrow. This is the width-generalised, sequential successor to the single-bit full-subtractor cell. It trades latency for area in datapaths that need wide subtraction with a start/done handshake. It also reports the final borrow and two's-complement overflow.

---
 rtl/serial_subtractor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes a - b - bin LSB-first, DIGIT bits per clock,
// with start/done handshake, final borrow and signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT (1 <= DIGIT <= WIDTH)");
  end

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic x, input logic y, input logic br);
    sub_cell = {(~x & y) | (~(x ^ y) & br), x ^ y ^ br};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             msb_in_s;
  logic             br_out_s;
  logic [WIDTH-1:0] shift_s;

  // Borrow chain across the current digit; msb_in_s is the borrow entering the top cell.
  always_comb begin
    logic       br_v;
    logic [1:0] cell_v;
    br_v     = br_q;
    msb_in_s = 1'b0;
    dig_s    = {DIGIT{1'b0}};
    for (int j = 0; j < DIGIT; j++) begin
      cell_v = sub_cell(a_q[j], b_q[j], br_v);
      dig_s[j] = cell_v[0];
      if (j == DIGIT - 1) begin
        msb_in_s = br_v;
      end else begin
        msb_in_s = msb_in_s;
      end
      br_v = cell_v[1];
    end
    br_out_s = br_v;
    // New digit enters at the top; after N steps the first digit sits at bit 0.
    shift_s  = WIDTH'({dig_s, acc_q} >> DIGIT);
  end

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          acc_d   = {WIDTH{1'b0}};
          br_d    = bin;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        acc_d = shift_s;
        br_d  = br_out_s;
        if (cnt_q == LAST_STEP) begin
          state_d = S_DONE;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = shift_s;
          bout_d  = br_out_s;
          ovf_d   = msb_in_s ^ br_out_s;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      br_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= {WIDTH{1'b0}};
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign diff     = diff_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule
